// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one-at-a-time imem requests and feeds IF/ID from a small FIFO.
// Optional FETCH_PERF_EN adds saturating bubble/flush/drop performance counters.
//
// state | meaning
// IDLE  | first cycle after reset release, no request
// REQ   | request issued when PCWrite and buffer space allow
// WAIT  | one request granted, response pending
// DROP  | granted response is stale (flushed), discard it on arrival
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [31:0]       NOP_INSTR  = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              PCWrite_i,
    input  logic              Stall_i,
    input  logic              NoOp_i,
    input  logic              Flush_i,
    input  logic [ADDR_W-1:0] Branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [ADDR_W-1:0] ID_pc_o,
    output logic [31:0]       ID_instr_o,
    output logic              ID_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_bubble_o,
    output logic [31:0]       perf_flush_o,
    output logic [31:0]       perf_drop_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, req_pc;
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
    logic [31:0]       fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              req, grant, push, pop, drop, load_bubble;

    // Only REQ can request, so the outstanding term is always zero here.
    assign req         = (state == ST_REQ) && PCWrite_i && (count < CNT_W'(FIFO_DEPTH));
    assign grant       = req && imem_gnt_i;
    assign push        = (state == ST_WAIT) && imem_rvalid_i && !Flush_i;
    assign drop        = imem_rvalid_i && ((state == ST_DROP) || ((state == ST_WAIT) && Flush_i));
    assign pop         = !Flush_i && !Stall_i && !NoOp_i && (count != '0);
    assign load_bubble = Flush_i || (!Stall_i && (NoOp_i || (count == '0)));

    assign imem_req_o  = req;
    assign imem_addr_o = pc;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ:  if (grant) state_nxt = Flush_i ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid_i)
                    state_nxt = ST_REQ;
                else if (Flush_i)
                    state_nxt = ST_DROP;
            end
            ST_DROP: if (imem_rvalid_i) state_nxt = ST_REQ;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (grant)
                req_pc <= pc;
            if (Flush_i)
                pc <= Branch_target_i;
            else if (grant)
                pc <= pc + ADDR_W'(4);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (Flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ID_valid_o <= 1'b0;
            ID_instr_o <= NOP_INSTR;
            ID_pc_o    <= '0;
        end else if (load_bubble) begin
            ID_valid_o <= 1'b0;
            ID_instr_o <= NOP_INSTR;
        end else if (pop) begin
            ID_valid_o <= 1'b1;
            ID_instr_o <= fifo_instr[rd_ptr];
            ID_pc_o    <= fifo_pc[rd_ptr];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_bubble_o <= '0;
            perf_flush_o  <= '0;
            perf_drop_o   <= '0;
        end else begin
            if (load_bubble && (perf_bubble_o != '1))
                perf_bubble_o <= perf_bubble_o + 32'd1;
            if (Flush_i && (perf_flush_o != '1))
                perf_flush_o <= perf_flush_o + 32'd1;
            if (drop && (perf_drop_o != '1))
                perf_drop_o <= perf_drop_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory model answers grants, a reference model
// predicts requests and IF/ID contents, and a monitor compares IF/ID after every clock edge.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        PCWrite_i, Stall_i, NoOp_i, Flush_i;
    logic [31:0] Branch_target_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i, ID_valid_o;
    logic [31:0] imem_addr_o, imem_rdata_i, ID_pc_o, ID_instr_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_o, perf_flush_o, perf_drop_o;
`endif

    fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .PCWrite_i(PCWrite_i), .Stall_i(Stall_i), .NoOp_i(NoOp_i),
        .Flush_i(Flush_i), .Branch_target_i(Branch_target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .ID_pc_o(ID_pc_o), .ID_instr_o(ID_instr_o), .ID_valid_o(ID_valid_o)
`ifdef FETCH_PERF_EN
        , .perf_bubble_o(perf_bubble_o), .perf_flush_o(perf_flush_o), .perf_drop_o(perf_drop_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; bit stale; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { bit v; logic [31:0] pc; logic [31:0] instr; } id_t;

    out_t        out_q[$];
    ent_t        fifo_q[$];
    id_t         exp_id_q[$];
    id_t         cur;
    logic [31:0] exp_pc;
    bit          started;
    int          n_vec = 0, n_err = 0;
    int          m_bubble = 0, m_flush = 0, m_drop = 0;

    bit          mem_pending = 0;
    int          mem_delay = 0;
    logic [31:0] mem_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        out_q.delete();
        fifo_q.delete();
        exp_id_q.delete();
        cur      = '{1'b0, 32'h0, NOP};
        exp_pc   = RST_PC;
        started  = 0;
        m_bubble = 0;
        m_flush  = 0;
        m_drop   = 0;
    endtask

    // Memory: grants 3 of 4 requests, answers 1..3 cycles after the grant.
    always begin
        @(posedge clk_i);
        #2;
        if (rst_i) begin
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
        end else begin
            imem_gnt_i    = imem_req_o && ($urandom_range(0, 3) != 0);
            imem_rvalid_i = mem_pending && (mem_delay == 0);
            imem_rdata_i  = imem_rvalid_i ? mem_word(mem_addr) : $urandom;
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            mem_pending = 0;
        end else begin
            assert (!imem_rvalid_i || mem_pending);
            if (imem_rvalid_i)
                mem_pending = 0;
            else if (mem_pending && mem_delay > 0)
                mem_delay--;
            if (imem_req_o && imem_gnt_i) begin
                mem_pending = 1;
                mem_addr    = imem_addr_o;
                mem_delay   = $urandom_range(0, 2);
            end
        end
    end

    // Reference model: evaluates the cycle's inputs and predicts IF/ID after the next edge.
    always @(negedge clk_i) begin
        out_t o;
        ent_t e;
        bit   accept;
        if (!rst_i) begin
            chk("imem_req", {31'b0, imem_req_o},
                {31'b0, started && out_q.size() == 0 && PCWrite_i && fifo_q.size() < DEPTH});
            if (imem_req_o && imem_gnt_i) begin
                chk("imem_addr", imem_addr_o, exp_pc);
                out_q.push_back('{exp_pc, Flush_i});
                exp_pc = exp_pc + 32'd4;
            end
            accept = 0;
            if (imem_rvalid_i && out_q.size() > 0) begin
                o = out_q.pop_front();
                if (o.stale || Flush_i)
                    m_drop++;
                else begin
                    accept = 1;
                    e = '{o.addr, mem_word(o.addr)};
                end
            end
            if (Flush_i) begin
                cur.v = 0; cur.instr = NOP; m_bubble++; m_flush++;
            end else if (!Stall_i) begin
                if (NoOp_i || fifo_q.size() == 0) begin
                    cur.v = 0; cur.instr = NOP; m_bubble++;
                end else begin
                    ent_t h;
                    h   = fifo_q.pop_front();
                    cur = '{1'b1, h.pc, h.instr};
                end
            end
            if (accept)
                fifo_q.push_back(e);
            if (Flush_i) begin
                fifo_q.delete();
                foreach (out_q[i]) out_q[i].stale = 1;
                exp_pc = Branch_target_i;
            end
            exp_id_q.push_back(cur);
            started = 1;
        end
    end

    // Monitor: pops one expected IF/ID state per clock edge.
    always begin
        id_t x;
        @(posedge clk_i);
        #1;
        if (!rst_i) begin
            if (exp_id_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL id_queue: got empty expectation queue, required one entry at %0t", $time);
            end else begin
                x = exp_id_q.pop_front();
                chk("ID_valid", {31'b0, ID_valid_o}, {31'b0, x.v});
                chk("ID_instr", ID_instr_o, x.instr);
                chk("ID_pc", ID_pc_o, x.pc);
            end
        end
    end

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0100;
            1:       return 32'hFFFF_FFFC;
            2:       return 32'hFFFF_FFF8;
            default: return {r[31:2], 2'b00};
        endcase
    endfunction

    task automatic drive(input int ps, input int pn, input int pf, input int ph);
        Stall_i         = int'($urandom_range(0, 99)) < ps;
        NoOp_i          = int'($urandom_range(0, 99)) < pn;
        Flush_i         = int'($urandom_range(0, 99)) < pf;
        PCWrite_i       = !(int'($urandom_range(0, 99)) < ph);
        Branch_target_i = pick_target();
    endtask

    task automatic run_phase(input int n, input int ps, input int pn, input int pf, input int ph);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            drive(ps, pn, pf, ph);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", {31'b0, imem_req_o}, 32'h0);
        chk("rst_addr", imem_addr_o, RST_PC);
        chk("rst_valid", {31'b0, ID_valid_o}, 32'h0);
        chk("rst_instr", ID_instr_o, NOP);
        chk("rst_pc", ID_pc_o, 32'h0);
    endtask

    initial begin
        bit found;
        PCWrite_i = 1; Stall_i = 0; NoOp_i = 0; Flush_i = 0; Branch_target_i = '0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs();
        #2;
        rst_i = 1'b0;

        run_phase(30, 0, 0, 0, 0);
        run_phase(300, 10, 10, 5, 10);
        run_phase(300, 75, 5, 3, 5);
        run_phase(300, 20, 10, 25, 10);

        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk_i);
            #1;
            drive(0, 0, 0, 0);
            found = mem_pending;
        end
        if (!found) begin
            n_vec++; n_err++;
            $display("FAIL reach_wait: got no outstanding request, required one within 100 cycles");
        end
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;

        run_phase(400, 25, 10, 8, 10);
        @(posedge clk_i);
        #1;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #2;
`ifdef FETCH_PERF_EN
        chk("perf_bubble", perf_bubble_o, m_bubble);
        chk("perf_flush", perf_flush_o, m_flush);
        chk("perf_drop", perf_drop_o, m_drop);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
